piece_rotator: RTL and testbench

PIECE_ROTATOR -- requirements
Module: piece_rotator

---
 rtl/piece_rotator.sv | 180 ++++++++++++++++++
 tb/tb_piece_rotator.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/piece_rotator.sv
// Falling-block piece holder: spawns shapes from an LFSR preview, proposes a
// rotated candidate to an external collision checker and commits it on approval.
module piece_rotator #(
  parameter int          N_SHAPES    = 7,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          FIT_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spawn,
  input  logic        rot_cw,
  input  logic        rot_ccw,
  input  logic        fit_valid,
  input  logic        fit_ok,
  output logic [2:0]  piece_id,
  output logic [1:0]  rotation,
  output logic [15:0] block_matrix,
  output logic [15:0] cand_matrix,
  output logic        cand_valid,
  output logic [2:0]  next_id,
  output logic        piece_active,
  output logic        busy,
  output logic        rot_done,
  output logic        rot_reject
);

  localparam logic [15:0] LP_SEED    = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
  localparam logic [7:0]  LP_N       = 8'(N_SHAPES);
  localparam logic [7:0]  LP_TO_LAST = 8'(FIT_TIMEOUT - 1);

  typedef enum logic {ST_IDLE, ST_CHECK} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_lfsr;
  logic [2:0]  r_piece_id;
  logic [1:0]  r_rotation;
  logic [2:0]  r_next_id;
  logic        r_active;
  logic [15:0] r_block;
  logic [15:0] r_cand;
  logic [1:0]  r_cand_rot;
  logic        r_cand_valid;
  logic        r_done;
  logic        r_reject;
  logic [7:0]  r_timer;

  logic        w_req;
  logic        w_start;
  logic        w_accept;
  logic        w_refuse;
  logic [1:0]  w_cand_rot;
  logic        w_lfsr_fb;

  function automatic logic [15:0] base_shape(input logic [2:0] id);
    case (id)
      3'd0:    return 16'h2222;
      3'd1:    return 16'h0660;
      3'd2:    return 16'h0C60;
      3'd3:    return 16'h4C40;
      3'd4:    return 16'h4460;
      3'd5:    return 16'h06C0;
      3'd6:    return 16'h2260;
      default: return 16'h0000;
    endcase
  endfunction

  // Bit 15 is row0/col0; one clockwise step is out[r][c] = in[3-c][r].
  function automatic logic [15:0] turn_cw(input logic [15:0] m);
    logic [15:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[15 - (4 * r + c)] = m[15 - (4 * (3 - c) + r)];
    return o;
  endfunction

  function automatic logic [15:0] shape(input logic [2:0] id, input logic [1:0] rot);
    logic [15:0] m;
    m = base_shape(id);
    case (rot)
      2'd0:    return m;
      2'd1:    return turn_cw(m);
      2'd2:    return turn_cw(turn_cw(m));
      default: return turn_cw(turn_cw(turn_cw(m)));
    endcase
  endfunction

  assign w_req      = r_active && (rot_cw ^ rot_ccw);
  assign w_cand_rot = rot_cw ? 2'(r_rotation + 2'd1) : 2'(r_rotation - 2'd1);
  assign w_lfsr_fb  = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_accept     = 1'b0;
    w_refuse     = 1'b0;
    if (spawn) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            w_state_next = ST_CHECK;
            w_start      = 1'b1;
          end
        end
        ST_CHECK: begin
          if (fit_valid) begin
            w_state_next = ST_IDLE;
            w_accept     = fit_ok;
            w_refuse     = !fit_ok;
          end else if (r_timer == LP_TO_LAST) begin
            w_state_next = ST_IDLE;
            w_refuse     = 1'b1;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr       <= LP_SEED;
      r_piece_id   <= '0;
      r_rotation   <= '0;
      r_next_id    <= '0;
      r_active     <= 1'b0;
      r_block      <= '0;
      r_cand       <= '0;
      r_cand_rot   <= '0;
      r_cand_valid <= 1'b0;
      r_done       <= 1'b0;
      r_reject     <= 1'b0;
      r_timer      <= '0;
    end else begin
      r_lfsr   <= {r_lfsr[14:0], w_lfsr_fb};
      r_done   <= w_accept;
      r_reject <= w_refuse;
      r_block  <= r_active ? shape(r_piece_id, r_rotation) : 16'h0000;
      if (spawn) begin
        r_piece_id   <= r_next_id;
        r_rotation   <= '0;
        r_active     <= 1'b1;
        r_next_id    <= 3'(r_lfsr[7:0] % LP_N);
        r_cand_valid <= 1'b0;
      end else if (w_start) begin
        r_cand       <= shape(r_piece_id, w_cand_rot);
        r_cand_rot   <= w_cand_rot;
        r_cand_valid <= 1'b1;
        r_timer      <= '0;
      end else if (w_accept || w_refuse) begin
        r_cand_valid <= 1'b0;
        if (w_accept) r_rotation <= r_cand_rot;
      end else if (r_state == ST_CHECK) begin
        r_timer <= r_timer + 8'd1;
      end
    end
  end

  assign piece_id     = r_piece_id;
  assign rotation     = r_rotation;
  assign block_matrix = r_block;
  assign cand_matrix  = r_cand;
  assign cand_valid   = r_cand_valid;
  assign next_id      = r_next_id;
  assign piece_active = r_active;
  assign busy         = (r_state == ST_CHECK);
  assign rot_done     = r_done;
  assign rot_reject   = r_reject;

endmodule

// File: tb/tb_piece_rotator.sv
// Directed bench for piece_rotator: hand-computed shape matrices, an LFSR
// reference for the preview id, and checks at the falling edge.
module tb_piece_rotator;

  logic        clk = 1'b0;
  logic        reset, spawn, rot_cw, rot_ccw, fit_valid, fit_ok;
  logic [2:0]  piece_id, next_id;
  logic [1:0]  rotation;
  logic [15:0] block_matrix, cand_matrix;
  logic        cand_valid, piece_active, busy, rot_done, rot_reject;

  int n_assert = 0;
  int n_fail   = 0;
  logic [15:0] m_lfsr;
  logic [2:0]  tb_next;

  piece_rotator dut (
    .clk(clk), .reset(reset), .spawn(spawn), .rot_cw(rot_cw), .rot_ccw(rot_ccw),
    .fit_valid(fit_valid), .fit_ok(fit_ok), .piece_id(piece_id), .rotation(rotation),
    .block_matrix(block_matrix), .cand_matrix(cand_matrix), .cand_valid(cand_valid),
    .next_id(next_id), .piece_active(piece_active), .busy(busy),
    .rot_done(rot_done), .rot_reject(rot_reject)
  );

  always #5 clk = ~clk;

  // Reference Fibonacci LFSR, taps 16,14,13,11.
  always @(posedge clk)
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_spawn();
    logic [2:0] exp_p;
    logic [7:0] low;
    low   = m_lfsr[7:0];
    exp_p = tb_next;
    spawn = 1'b1;
    tick();
    spawn = 1'b0;
    tb_next = 3'(low % 8'd7);
    chk("spawn_piece_id", 16'(piece_id), 16'(exp_p));
    chk("spawn_next_id", 16'(next_id), 16'(tb_next));
    chk("spawn_rotation", 16'(rotation), 16'd0);
    chk("spawn_active", 16'(piece_active), 16'd1);
  endtask

  task automatic spawn_until(input logic [2:0] target);
    int guard;
    guard = 0;
    while (tb_next != target && guard < 200) begin
      do_spawn();
      guard++;
    end
    chk("spawn_until_found", 16'(tb_next), 16'(target));
    do_spawn();
  endtask

  // Request one rotation and resolve it with the given verdict.
  task automatic rotate(input logic cw, input logic ok, input logic [15:0] exp_cand,
                        input logic [1:0] exp_rot);
    rot_cw  = cw;
    rot_ccw = !cw;
    tick();
    rot_cw  = 1'b0;
    rot_ccw = 1'b0;
    chk("req_cand_valid", 16'(cand_valid), 16'd1);
    chk("req_cand_matrix", cand_matrix, exp_cand);
    chk("req_busy", 16'(busy), 16'd1);
    fit_valid = 1'b1;
    fit_ok    = ok;
    tick();
    fit_valid = 1'b0;
    fit_ok    = 1'b0;
    chk("fit_done", 16'(rot_done), 16'(ok));
    chk("fit_reject", 16'(rot_reject), 16'(!ok));
    chk("fit_rotation", 16'(rotation), 16'(exp_rot));
    chk("fit_busy", 16'(busy), 16'd0);
    chk("fit_cand_valid", 16'(cand_valid), 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; spawn = 1'b0; rot_cw = 1'b0; rot_ccw = 1'b0;
    fit_valid = 1'b0; fit_ok = 1'b0; tb_next = 3'd0;
    repeat (3) tick();
    chk("rst_piece_id", 16'(piece_id), 16'd0);
    chk("rst_rotation", 16'(rotation), 16'd0);
    chk("rst_next_id", 16'(next_id), 16'd0);
    chk("rst_active", 16'(piece_active), 16'd0);
    chk("rst_block", block_matrix, 16'h0000);
    chk("rst_cand", cand_matrix, 16'h0000);
    chk("rst_cand_valid", 16'(cand_valid), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_pulses", 16'({rot_done, rot_reject}), 16'd0);
    reset = 1'b0;

    // First spawn brings in the I piece; matrix follows one cycle later.
    do_spawn();
    chk("i_block_lag", block_matrix, 16'h0000);
    tick();
    chk("i_block", block_matrix, 16'h2222);

    rotate(1'b1, 1'b1, 16'h00F0, 2'd1);
    tick();
    chk("i_done_pulse_end", 16'(rot_done), 16'd0);
    chk("i_block_r1", block_matrix, 16'h00F0);

    // Both directions at once, and a stray verdict in IDLE: nothing happens.
    rot_cw = 1'b1; rot_ccw = 1'b1;
    tick();
    rot_cw = 1'b0; rot_ccw = 1'b0;
    chk("both_busy", 16'(busy), 16'd0);
    chk("both_cand_valid", 16'(cand_valid), 16'd0);
    fit_valid = 1'b1; fit_ok = 1'b1;
    tick();
    fit_valid = 1'b0; fit_ok = 1'b0;
    chk("idle_fit_pulses", 16'({rot_done, rot_reject}), 16'd0);
    chk("idle_fit_rotation", 16'(rotation), 16'd1);

    // Timeout: candidate held for 15 cycles, then rejected.
    rot_cw = 1'b1;
    tick();
    rot_cw = 1'b0;
    chk("to_cand", cand_matrix, 16'h4444);
    chk("to_cand_valid", 16'(cand_valid), 16'd1);
    for (int i = 1; i < 15; i++) begin
      rot_ccw = (i == 3);
      tick();
      chk("to_wait_busy", 16'(busy), 16'd1);
      chk("to_wait_reject", 16'(rot_reject), 16'd0);
    end
    rot_ccw = 1'b0;
    tick();
    chk("to_reject", 16'(rot_reject), 16'd1);
    chk("to_busy", 16'(busy), 16'd0);
    chk("to_rotation", 16'(rotation), 16'd1);
    tick();
    chk("to_pulse_end", 16'(rot_reject), 16'd0);

    // Spawn while checking wins over a simultaneous approval.
    rot_cw = 1'b1;
    tick();
    rot_cw = 1'b0;
    chk("ab_busy", 16'(busy), 16'd1);
    fit_valid = 1'b1; fit_ok = 1'b1;
    do_spawn();
    fit_valid = 1'b0; fit_ok = 1'b0;
    chk("ab_pulses", 16'({rot_done, rot_reject}), 16'd0);
    chk("ab_cand_valid", 16'(cand_valid), 16'd0);
    chk("ab_busy_after", 16'(busy), 16'd0);
    tick();
    chk("ab_pulses_late", 16'({rot_done, rot_reject}), 16'd0);

    // O piece: counter-clockwise from 0, rejected.
    spawn_until(3'd1);
    rotate(1'b0, 1'b0, 16'h0660, 2'd0);
    tick();
    chk("o_block", block_matrix, 16'h0660);

    // T piece: four accepted clockwise turns, then a wrapping ccw turn.
    spawn_until(3'd3);
    rotate(1'b1, 1'b1, 16'h2700, 2'd1);
    rotate(1'b1, 1'b1, 16'h0232, 2'd2);
    rotate(1'b1, 1'b1, 16'h00E4, 2'd3);
    rotate(1'b1, 1'b1, 16'h4C40, 2'd0);
    tick();
    chk("t_block_final", block_matrix, 16'h4C40);
    rotate(1'b0, 1'b1, 16'h00E4, 2'd3);
    tick();
    chk("t_block_ccw", block_matrix, 16'h00E4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
